// File: rtl/pulse_dec_pkg.sv
// rtl/pulse_dec_pkg.sv - shared widths and state encoding for the 3:8 pulse decoder
package pulse_dec_pkg;

  localparam int SEL_W = 3;
  localparam int OUT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    GAP
  } pdec_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dec3_8_str.sv
// rtl/dec3_8_str.sv - gate-level combinational 3:8 decoder with enable
module dec3_8_str
  import pulse_dec_pkg::*;
(
  input  logic             en_i,
  input  logic [SEL_W-1:0] code_i,
  output logic [OUT_W-1:0] onehot_o
);

  logic [SEL_W-1:0] code_n;

  assign code_n = ~code_i;

  assign onehot_o[0] = en_i & code_n[2] & code_n[1] & code_n[0];
  assign onehot_o[1] = en_i & code_n[2] & code_n[1] & code_i[0];
  assign onehot_o[2] = en_i & code_n[2] & code_i[1] & code_n[0];
  assign onehot_o[3] = en_i & code_n[2] & code_i[1] & code_i[0];
  assign onehot_o[4] = en_i & code_i[2] & code_n[1] & code_n[0];
  assign onehot_o[5] = en_i & code_i[2] & code_n[1] & code_i[0];
  assign onehot_o[6] = en_i & code_i[2] & code_i[1] & code_n[0];
  assign onehot_o[7] = en_i & code_i[2] & code_i[1] & code_i[0];

endmodule

// File: rtl/pulse_dec3_8_seq.sv
// rtl/pulse_dec3_8_seq.sv - handshaked 3:8 decoder driving a timed one-hot pulse and idle gap
module pulse_dec3_8_seq
  import pulse_dec_pkg::*;
#(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic [SEL_W-1:0] in_code,
  output logic             in_ready,
  output logic [OUT_W-1:0] onehot,
  output logic             active,
  output logic             done,
  output logic [SEL_W-1:0] code_q
);

  localparam int CNT_W = $clog2(max3(PULSE_LEN, GAP_LEN, 2));
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
  localparam bit HAS_GAP = (GAP_LEN > 0);

  pdec_state_t      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [OUT_W-1:0] onehot_q;
  logic [OUT_W-1:0] onehot_d;
  logic             active_q;
  logic             done_q;
  logic             last_cycle;
  logic             can_take;
  logic             accept;

  assign last_cycle = (state_q == ACTIVE) && (cnt_q == '0);
  // Without a gap the final pulse cycle also takes the next code, so pulses abut.
  assign can_take   = (state_q == IDLE) || (!HAS_GAP && last_cycle);
  assign in_ready   = rst_n & en & can_take;
  assign accept     = in_valid & in_ready;

  dec3_8_str u_dec (
    .en_i     (accept),
    .code_i   (in_code),
    .onehot_o (onehot_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      onehot_q <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      code_q   <= '0;
    end else if (!en) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      onehot_q <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            code_q   <= in_code;
            onehot_q <= onehot_d;
            active_q <= 1'b1;
            cnt_q    <= PULSE_LOAD;
            state_q  <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            done_q <= 1'b1;
            if (accept) begin
              code_q   <= in_code;
              onehot_q <= onehot_d;
              active_q <= 1'b1;
              cnt_q    <= PULSE_LOAD;
            end else if (HAS_GAP) begin
              onehot_q <= '0;
              active_q <= 1'b0;
              cnt_q    <= GAP_LOAD;
              state_q  <= GAP;
            end else begin
              onehot_q <= '0;
              active_q <= 1'b0;
              state_q  <= IDLE;
            end
          end
        end
        GAP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q  <= IDLE;
          cnt_q    <= '0;
          onehot_q <= '0;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign onehot = onehot_q;
  assign active = active_q;
  assign done   = done_q;

endmodule

// File: tb/tb_pulse_dec3_8_seq.sv
// tb/tb_pulse_dec3_8_seq.sv - directed bench for pulse_dec3_8_seq (4/1 and 2/0 configurations)
module tb_pulse_dec3_8_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       in_valid;
  logic [2:0] in_code;

  logic       a_ready, a_active, a_done;
  logic [7:0] a_onehot;
  logic [2:0] a_code;
  logic       b_ready, b_active, b_done;
  logic [7:0] b_onehot;
  logic [2:0] b_code;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_on  = 1'b0;

  always #5 clk = ~clk;

  pulse_dec3_8_seq #(.PULSE_LEN(4), .GAP_LEN(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_code(in_code),
    .in_ready(a_ready), .onehot(a_onehot), .active(a_active), .done(a_done), .code_q(a_code)
  );

  pulse_dec3_8_seq #(.PULSE_LEN(2), .GAP_LEN(0)) u_b2b (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_code(in_code),
    .in_ready(b_ready), .onehot(b_onehot), .active(b_active), .done(b_done), .code_q(b_code)
  );

  always @(negedge clk) begin
    if (chk_on) begin
      n_total++;
      if ($countones(a_onehot) <= 1 && a_active === (|a_onehot)) n_pass++;
      else $display("FAIL invariant_a onehot=%h active=%b required one-hot/zero with active=|onehot", a_onehot, a_active);
      n_total++;
      if ($countones(b_onehot) <= 1 && b_active === (|b_onehot)) n_pass++;
      else $display("FAIL invariant_b onehot=%h active=%b required one-hot/zero with active=|onehot", b_onehot, b_active);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; in_valid = 1'b1; in_code = 3'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_on = 1'b1;
      n_total++;
      if ({a_onehot, a_active, a_done, a_ready, a_code} !== 13'd0) begin
        $display("FAIL reset_hold cyc=%0d onehot=%h active=%b done=%b ready=%b code_q=%0d required all 0",
                 i, a_onehot, a_active, a_done, a_ready, a_code);
      end else n_pass++;
    end
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    n_total++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1) $display("FAIL reset_release ready a=%b b=%b required 1", a_ready, b_ready);
    else n_pass++;
  endtask

  task automatic test_single_pulse();
    in_valid = 1'b1; in_code = 3'd5;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (a_onehot !== 8'h20 || a_done !== 1'b0 || a_ready !== 1'b0)
        $display("FAIL single_pulse cyc=%0d onehot=%h done=%b ready=%b required 20/0/0", i, a_onehot, a_done, a_ready);
      else n_pass++;
      step();
    end
    n_total++;
    if (a_onehot !== 8'h00 || a_done !== 1'b1 || a_ready !== 1'b0)
      $display("FAIL single_gap onehot=%h done=%b ready=%b required 00/1/0", a_onehot, a_done, a_ready);
    else n_pass++;
    step();
    n_total++;
    if (a_onehot !== 8'h00 || a_done !== 1'b0 || a_ready !== 1'b1 || a_code !== 3'd5)
      $display("FAIL single_idle onehot=%h done=%b ready=%b code_q=%0d required 00/0/1/5", a_onehot, a_done, a_ready, a_code);
    else n_pass++;
  endtask

  task automatic test_sweep();
    logic [7:0] exp;
    for (int c = 0; c < 8; c++) begin
      exp = 8'b1 << c;
      in_valid = 1'b1; in_code = 3'(c);
      step();
      in_valid = 1'b0;
      n_total++;
      if (a_onehot !== exp || a_code !== 3'(c))
        $display("FAIL sweep code=%0d onehot=%h code_q=%0d required %h/%0d", c, a_onehot, a_code, exp, c);
      else n_pass++;
      for (int k = 0; k < 5; k++) step();
      n_total++;
      if (a_ready !== 1'b1) $display("FAIL sweep_ready code=%0d ready=%b required 1", c, a_ready);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_oh [4];
    logic       exp_dn [4];
    exp_oh = '{8'h08, 8'h08, 8'h40, 8'h40};
    exp_dn = '{1'b0, 1'b0, 1'b1, 1'b0};
    n_total++;
    if (b_ready !== 1'b1) $display("FAIL b2b_start ready=%b required 1", b_ready);
    else n_pass++;
    in_valid = 1'b1; in_code = 3'd3;
    step();
    in_code = 3'd6;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (b_onehot !== exp_oh[i] || b_done !== exp_dn[i])
        $display("FAIL b2b cyc=%0d onehot=%h done=%b required %h/%b", i, b_onehot, b_done, exp_oh[i], exp_dn[i]);
      else n_pass++;
      if (i == 1) begin
        n_total++;
        if (b_ready !== 1'b1) $display("FAIL b2b_last_ready ready=%b required 1", b_ready);
        else n_pass++;
      end
      if (i == 2) in_valid = 1'b0;
      step();
    end
    n_total++;
    if (b_onehot !== 8'h00 || b_done !== 1'b1 || b_code !== 3'd6)
      $display("FAIL b2b_end onehot=%h done=%b code_q=%0d required 00/1/6", b_onehot, b_done, b_code);
    else n_pass++;
    for (int k = 0; k < 3; k++) step();
  endtask

  task automatic test_abort();
    n_total++;
    if (a_ready !== 1'b1) $display("FAIL abort_start ready=%b required 1", a_ready);
    else n_pass++;
    in_valid = 1'b1; in_code = 3'd2;
    step();
    in_valid = 1'b0;
    step();
    n_total++;
    if (a_onehot !== 8'h04) $display("FAIL abort_pulse onehot=%h required 04", a_onehot);
    else n_pass++;
    en = 1'b0;
    #1;
    n_total++;
    if (a_ready !== 1'b0) $display("FAIL abort_ready_low ready=%b required 0", a_ready);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++;
      if (a_onehot !== 8'h00 || a_active !== 1'b0 || a_done !== 1'b0 || a_code !== 3'd2)
        $display("FAIL abort cyc=%0d onehot=%h active=%b done=%b code_q=%0d required 00/0/0/2",
                 i, a_onehot, a_active, a_done, a_code);
      else n_pass++;
    end
    en = 1'b1;
    #1;
    n_total++;
    if (a_ready !== 1'b1) $display("FAIL abort_resume ready=%b required 1", a_ready);
    else n_pass++;
  endtask

  task automatic test_stall_and_reset();
    in_valid = 1'b1; in_code = 3'd1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    in_valid = 1'b1; in_code = 3'd7;
    #1;
    n_total++;
    if (a_ready !== 1'b0 || a_done !== 1'b1) $display("FAIL stall_gap ready=%b done=%b required 0/1", a_ready, a_done);
    else n_pass++;
    step();
    n_total++;
    if (a_onehot !== 8'h00 || a_ready !== 1'b1 || a_code !== 3'd1)
      $display("FAIL stall_idle onehot=%h ready=%b code_q=%0d required 00/1/1", a_onehot, a_ready, a_code);
    else n_pass++;
    step();
    in_valid = 1'b0;
    n_total++;
    if (a_onehot !== 8'h80 || a_code !== 3'd7)
      $display("FAIL stall_accept onehot=%h code_q=%0d required 80/7", a_onehot, a_code);
    else n_pass++;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_total++;
    if (a_onehot !== 8'h00 || a_code !== 3'd0 || a_done !== 1'b0)
      $display("FAIL midpulse_reset onehot=%h code_q=%0d done=%b required 00/0/0", a_onehot, a_code, a_done);
    else n_pass++;
    step();
    n_total++;
    if (a_onehot !== 8'h00 || a_active !== 1'b0 || a_done !== 1'b0)
      $display("FAIL post_reset onehot=%h active=%b done=%b required 00/0/0", a_onehot, a_active, a_done);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_sweep();
    test_back_to_back();
    test_abort();
    test_stall_and_reset();
    step();
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
